// File: rtl/lsu_pkg.sv
// Shared load/store unit types: funct3 codes, FSM states, latched request, size and legality decode.
package lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ0,
    ST_WAIT0,
    ST_REQ1,
    ST_WAIT1,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  offset;
    logic [31:0] wdata;
    logic        split;
    logic        err;
  } req_t;

  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    if (we)
      funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else
      funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                     (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store shift/strobes for two beats, load gather and sign/zero extend.
// Zero latency; no handshake, consumed by the load_store_unit FSM.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] st_data,
  output logic [31:0] st_wdata0,
  output logic [31:0] st_wdata1,
  output logic [3:0]  st_wstrb0,
  output logic [3:0]  st_wstrb1,
  input  logic [31:0] ld_word0,
  input  logic [23:0] ld_word1,
  output logic [31:0] ld_data
);

  logic [3:0]  size_mask;
  logic [7:0]  strb_wide;
  logic [31:0] gathered;
  logic        sign;

  always_comb begin
    case (size_bytes(funct3))
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    strb_wide = {4'b0000, size_mask} << offset;
    st_wstrb0 = strb_wide[3:0];
    st_wstrb1 = strb_wide[7:4];
  end

  // Beat 1 only ever carries bytes that spilled past lane 3, so its top byte is never used.
  always_comb begin
    case (offset)
      2'd0: begin
        st_wdata0 = st_data;
        st_wdata1 = 32'h0;
        gathered  = ld_word0;
      end
      2'd1: begin
        st_wdata0 = {st_data[23:0], 8'h00};
        st_wdata1 = {24'h0, st_data[31:24]};
        gathered  = {ld_word1[7:0], ld_word0[31:8]};
      end
      2'd2: begin
        st_wdata0 = {st_data[15:0], 16'h0000};
        st_wdata1 = {16'h0, st_data[31:16]};
        gathered  = {ld_word1[15:0], ld_word0[31:16]};
      end
      default: begin
        st_wdata0 = {st_data[7:0], 24'h0};
        st_wdata1 = {8'h0, st_data[31:8]};
        gathered  = {ld_word1[23:0], ld_word0[31:24]};
      end
    endcase
  end

  always_comb begin
    sign    = 1'b0;
    ld_data = gathered;
    case (funct3[1:0])
      2'b00: begin
        sign    = ~funct3[2] & gathered[7];
        ld_data = {{24{sign}}, gathered[7:0]};
      end
      2'b01: begin
        sign    = ~funct3[2] & gathered[15];
        ld_data = {{16{sign}}, gathered[15:0]};
      end
      default: ld_data = gathered;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Handshaked RISC-V load/store unit; 3 cycles accept-to-response best case, +2 when split, 1 on error.
// Accepts only in IDLE; mem_* hold stable until mem_gnt; one memory beat outstanding at a time.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int WA_W = ADDR_W - 2;

  state_e          state_q, state_d;
  req_t            req_q;
  logic [WA_W-1:0] word_q;
  logic [31:0]     rdata0_q, rdata_q;

  logic        accept, crossing, acc_err, last_beat_done;
  logic [31:0] wdata0, wdata1, ld_word0, ld_data;
  logic [3:0]  wstrb0, wstrb1;

  assign accept         = req_valid && req_ready;
  assign crossing       = ({1'b0, req_addr[1:0]} + size_bytes(req_funct3)) > 3'd4;
  assign acc_err        = !funct3_legal(req_we, req_funct3) || (crossing && !MISALIGNED_EN);
  assign ld_word0       = (state_q == ST_WAIT1) ? rdata0_q : mem_rdata;
  assign last_beat_done = mem_rvalid &&
                          (((state_q == ST_WAIT0) && !req_q.split) || (state_q == ST_WAIT1));

  lsu_align u_align (
    .funct3    (req_q.funct3),
    .offset    (req_q.offset),
    .st_data   (req_q.wdata),
    .st_wdata0 (wdata0),
    .st_wdata1 (wdata1),
    .st_wstrb0 (wstrb0),
    .st_wstrb1 (wstrb1),
    .ld_word0  (ld_word0),
    .ld_word1  (mem_rdata[23:0]),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      word_q   <= '0;
      rdata0_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= '{we: req_we, funct3: req_funct3, offset: req_addr[1:0],
                   wdata: req_wdata, split: crossing, err: acc_err};
        word_q  <= req_addr[ADDR_W-1:2];
        rdata_q <= '0;
      end
      if ((state_q == ST_WAIT0) && mem_rvalid) rdata0_q <= mem_rdata;
      // Stores and errors leave rdata_q at zero from the accept clear.
      if (last_beat_done && !req_q.we) rdata_q <= ld_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wstrb  = '0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = acc_err ? ST_RESP : ST_REQ0;
      end
      ST_REQ0: begin
        mem_req   = 1'b1;
        mem_we    = req_q.we;
        mem_addr  = {word_q, 2'b00};
        mem_wdata = req_q.we ? wdata0 : 32'h0;
        mem_wstrb = req_q.we ? wstrb0 : 4'h0;
        if (mem_gnt) state_d = ST_WAIT0;
      end
      ST_WAIT0: begin
        if (mem_rvalid) state_d = req_q.split ? ST_REQ1 : ST_RESP;
      end
      ST_REQ1: begin
        mem_req   = 1'b1;
        mem_we    = req_q.we;
        mem_addr  = {word_q + WA_W'(1), 2'b00};
        mem_wdata = req_q.we ? wdata1 : 32'h0;
        mem_wstrb = req_q.we ? wstrb1 : 4'h0;
        if (mem_gnt) state_d = ST_WAIT1;
      end
      ST_WAIT1: begin
        if (mem_rvalid) state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = req_q.err;
        resp_rdata = rdata_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit placed between the RISC-V CPU datapath and data memory. It replaces the combinational byte-select and extend logic that sat on `ReadData` with a handshaked, parametrised unit. It supports LB/LH/LW/LBU/LHU/SB/SH/SW, a memory with variable grant and response latency, and optional hardware splitting of misaligned accesses that cross a word boundary.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width; memory side is word-addressed (`ADDR_W-2` upper bits significant).
- `MISALIGNED_EN`, 1, 1 = split word-crossing accesses into two memory beats; 0 = flag them as errors.

Ports (one clock `clk`; `Reset` is synchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge
- `Reset`  in  1  synchronous, active-high
- `req_valid`  in  1  CPU presents an access
- `req_ready`  out  1  unit can accept (high only in IDLE)
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RISC-V funct3 of the load/store
- `req_addr`  in  ADDR_W  byte address (ALUResult)
- `req_wdata`  in  32  store data (rs2)
- `resp_valid`  out  1  one-cycle completion pulse
- `resp_rdata`  out  32  extended load result (0 for stores/errors)
- `resp_err`  out  1  illegal funct3 or disallowed misalignment
- `mem_req`  out  1  memory beat request
- `mem_we`  out  1  beat is a write
- `mem_addr`  out  ADDR_W  word-aligned address (`[1:0]`=0)
- `mem_wdata`  out  32  lane-shifted write data
- `mem_wstrb`  out  4  byte enables, bit i = byte lane i
- `mem_gnt`  in  1  memory accepts the beat this cycle
- `mem_rvalid`  in  1  beat complete (read data or write ack)
- `mem_rdata`  in  32  read word, little-endian

## Operation
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000/001/010. Any other code yields `resp_err`=1 with no memory beat.
- Size bytes: B=1, H=2, W=4. Crossing = `addr[1:0]+size > 4`. A non-crossing misaligned halfword (offset 1) is a single beat.
- Crossing with `MISALIGNED_EN`=0: error response, no beat. With 1: beat 0 at `addr & ~3` covers the low lanes from offset upward; beat 1 at `(addr & ~3)+4` covers the remainder from lane 0.
- Stores: data is shifted left by 8·offset; beat 0 gets the low part, beat 1 gets the spilled high bytes in lanes from 0; `mem_wstrb` marks only written lanes.
- Loads: bytes are gathered from beat 0 (upper lanes) and beat 1 (lower lanes), then right-aligned; LB/LH are sign-extended, LBU/LHU zero-extended.
- FSM: IDLE → REQ0 (`mem_req`=1 until `mem_gnt`) → WAIT0 (until `mem_rvalid`) → REQ1 → WAIT1 if split, else → RESP. RESP drives `resp_valid` for one cycle, then returns to IDLE. Error path: IDLE → RESP.
- At most one beat is outstanding. Request fields are latched on accept (`req_valid && req_ready`).

## Timing
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0.
- Best case, aligned, `mem_gnt` same cycle and `mem_rvalid` next cycle: accept at cycle 0, `mem_req` at 1, `mem_rvalid` at 2, `resp_valid` at 3. A split access adds 2 cycles.
- Error latency: `resp_valid` one cycle after accept.
- `mem_*` outputs hold stable while `mem_req`=1 && !`mem_gnt`.
- A `mem_rvalid` arriving in the same cycle as `mem_gnt` is not allowed by the memory contract. A `mem_rvalid` outside WAIT0/WAIT1 is ignored.
- `Reset` mid-operation: IDLE on the next edge, `mem_req` drops, and any late `mem_rvalid` is ignored. No `resp_valid` is produced for the aborted access.
- `resp_rdata` and `resp_err` are valid only while `resp_valid`=1.

## Structure
- `lsu_pkg`: funct3 constants/enum, state enum, size-decode function.
- Sub-module `lsu_align`, purely combinational: store lane shift and strobe generation, and load gather/extract/extend from two words and the offset. The FSM, latches and beat-0 data register stay in `load_store_unit`.

## Test plan
- LB @0x60, word 0x01B1061A → `resp_rdata`=0x0000001A. LB @0x63, word 0xA1230207 → 0xFFFFFFA1. LBU @0x63 → 0x000000A1.
- LH @0x62, word 0xA1230207 → 0xFFFFA123. LHU → 0x0000A123. Single beat, `mem_addr`=0x60.
- LW @0x62, `MISALIGNED_EN`=1, words 0xA1230207@0x60 and 0x01B1061A@0x64 → beats 0x60 then 0x64, result 0x061AA123, latency 5 with zero-wait memory. With `MISALIGNED_EN`=0 → `resp_err`=1, no `mem_req`.
- SW 0x11223344 @0x63 → beat 0x60, wstrb 1000, wdata 0x44000000. Then beat 0x64, wstrb 0111, wdata 0x00112233.
- `mem_gnt` delayed 3 cycles and `mem_rvalid` 2 more on SB @0x61 data 0xAB → `mem_*` stable while stalled, wstrb 0010, wdata 0x0000AB00, one `resp_valid`.
- funct3 011 → `resp_err`=1 next cycle. `Reset` asserted in WAIT0 → IDLE and `mem_req`=0 the next cycle, no `resp_valid` even if `mem_rvalid` arrives later.
